// File: rtl/line_fetcher.sv
// line_fetcher: PSRAM framebuffer line fetch into an RGB888 line buffer.
// Optional test-pattern source is built when LINE_FETCH_PATTERN_EN is defined.

module line_fetcher #(
  parameter int H_ACTIVE  = 800,
  parameter int BURST_LEN = 16,
  parameter int FB_BASE   = 0,
  parameter int ADDR_W    = 22
) (
  input  logic              clk_psram,
  input  logic              rst_n,
  input  logic              line_req,
  input  logic [9:0]        line_idx,
`ifdef LINE_FETCH_PATTERN_EN
  input  logic              pattern_sel,
`endif
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ack,
  input  logic              mem_rd_valid,
  input  logic [15:0]       mem_rd_data,
  output logic [9:0]        wr_addr,
  output logic [23:0]       wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              overrun,
  output logic [7:0]        overrun_cnt
);

  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam int PX_W   = $clog2(H_ACTIVE + 1);

  localparam logic [PX_W-1:0]   PX_LAST = PX_W'(H_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] BASE0   = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0] LINE_W  = ADDR_W'(H_ACTIVE);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] line_base;
  logic [PX_W-1:0]   px_q;
  logic [BEAT_W-1:0] beat_q;
  logic [23:0]       px_rgb;

  logic pat_start;
  logic pat_q;
  logic last_px;
  logic last_beat;
  logic mem_step;
  logic pat_step;

`ifdef LINE_FETCH_PATTERN_EN
  logic [7:0] idx_q;

  assign pat_start = pattern_sel;

  always_ff @(posedge clk_psram or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= 1'b0;
      idx_q <= '0;
    end else if (state_q == IDLE && line_req) begin
      pat_q <= pattern_sel;
      idx_q <= line_idx[7:0];
    end
  end
`else
  assign pat_start = 1'b0;
  assign pat_q     = 1'b0;
`endif

  // Address arithmetic wraps modulo 2^ADDR_W by truncation.
  assign line_base = BASE0 + ADDR_W'(line_idx) * LINE_W;

  assign last_px   = px_q == PX_LAST;
  assign last_beat = beat_q == '1;
  assign mem_step  = state_q == DATA && !pat_q && mem_rd_valid;
  assign pat_step  = state_q == DATA && pat_q;

  assign mem_rd_req  = state_q == REQ;
  assign mem_rd_addr = mem_rd_req ? base_q + ADDR_W'(px_q) : '0;
  assign busy        = state_q != IDLE;

  always_comb begin
    px_rgb = {mem_rd_data[15:11], mem_rd_data[15:13],
              mem_rd_data[10:5],  mem_rd_data[10:9],
              mem_rd_data[4:0],   mem_rd_data[4:2]};
`ifdef LINE_FETCH_PATTERN_EN
    if (pat_q) begin
      px_rgb = {8'(px_q), idx_q, 8'(px_q) ^ idx_q};
    end
`endif
  end

  always_ff @(posedge clk_psram or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (line_req) begin
          state_d = pat_start ? DATA : REQ;
        end
      end
      REQ: begin
        if (mem_rd_ack) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (pat_step && last_px) begin
          state_d = DONE;
        end else if (mem_step && last_beat) begin
          state_d = last_px ? DONE : REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_psram or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= '0;
      px_q        <= '0;
      beat_q      <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      wr_en   <= 1'b0;
      overrun <= 1'b0;

      if (line_req && state_q != IDLE) begin
        overrun <= 1'b1;
        if (overrun_cnt != 8'hFF) begin
          overrun_cnt <= overrun_cnt + 8'd1;
        end
      end

      if (state_q == IDLE && line_req) begin
        base_q <= line_base;
        px_q   <= '0;
      end

      if (state_q == REQ && mem_rd_ack) begin
        beat_q <= '0;
      end

      if (mem_step || pat_step) begin
        wr_en   <= 1'b1;
        wr_addr <= 10'(px_q);
        wr_data <= px_rgb;
        px_q    <= px_q + 1'b1;
        beat_q  <= beat_q + 1'b1;
      end
    end
  end

endmodule
